// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer driving a 32-bit ALU, with 64-bit chaining and NZCV register
module alu_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic [4:0]  Req_OP,
    input  logic        Req_Wide,
    input  logic        Req_S,
    input  logic [63:0] Req_A,
    input  logic [63:0] Req_B,
    output logic        Rsp_Valid,
    input  logic        Rsp_Ready,
    output logic [63:0] Rsp_Result,
    output logic [3:0]  Flags,
    output logic        Busy,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [4:0]  ALU_OP,
    output logic        ALU_Cin,
    input  logic [31:0] ALU_Out,
    input  logic        ALU_Z,
    input  logic        ALU_V,
    input  logic        ALU_N,
    input  logic        ALU_C
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] OP_IDLE = 5'b10000;

    logic [1:0]  state_q,   state_d;
    logic [4:0]  op_q,      op_d;
    logic        wide_q,    wide_d;
    logic        s_q,       s_d;
    logic [63:0] a_q,       a_d;
    logic [63:0] b_q,       b_d;
    logic [31:0] lo_res_q,  lo_res_d;
    logic        lo_z_q,    lo_z_d;
    logic        lo_c_q,    lo_c_d;
    logic [63:0] result_q,  result_d;
    logic [3:0]  flags_q,   flags_d;

    // High pass turns the plain op into its carry-consuming counterpart.
    function automatic logic [4:0] hi_opcode(input logic [4:0] op);
        case (op)
            5'd4, 5'd11: hi_opcode = 5'd5;
            5'd2, 5'd10: hi_opcode = 5'd6;
            5'd3:        hi_opcode = 5'd7;
            default:     hi_opcode = op;
        endcase
    endfunction

    function automatic logic is_add_class(input logic [4:0] op);
        is_add_class = (op == 5'd4) || (op == 5'd5) || (op == 5'd11);
    endfunction

    function automatic logic is_sub_class(input logic [4:0] op);
        is_sub_class = (op == 5'd2) || (op == 5'd3) || (op == 5'd6) ||
                       (op == 5'd7) || (op == 5'd10);
    endfunction

    function automatic logic is_arith(input logic [4:0] op);
        is_arith = ((op >= 5'd2) && (op <= 5'd7)) || (op == 5'd10) ||
                   (op == 5'd11) || (op == 5'd17) || (op == 5'd18);
    endfunction

    function automatic logic writes_flags(input logic s, input logic [4:0] op);
        writes_flags = s || ((op >= 5'd8) && (op <= 5'd11));
    endfunction

    assign Req_Ready  = (state_q == ST_IDLE);
    assign Busy       = (state_q != ST_IDLE);
    assign Rsp_Valid  = (state_q == ST_DONE);
    assign Rsp_Result = result_q;
    assign Flags      = flags_q;

    always_comb begin
        ALU_A   = 32'd0;
        ALU_B   = 32'd0;
        ALU_OP  = OP_IDLE;
        ALU_Cin = 1'b0;
        case (state_q)
            ST_LO: begin
                ALU_A   = a_q[31:0];
                ALU_B   = b_q[31:0];
                ALU_OP  = op_q;
                ALU_Cin = ((op_q == 5'd5) || (op_q == 5'd6) || (op_q == 5'd7)) ? flags_q[1] : 1'b0;
            end
            ST_HI: begin
                ALU_A  = a_q[63:32];
                ALU_B  = b_q[63:32];
                ALU_OP = hi_opcode(op_q);
                // The ALU reports borrow on subtracts, so the chained carry is inverted.
                if (is_add_class(op_q)) begin
                    ALU_Cin = lo_c_q;
                end else if (is_sub_class(op_q)) begin
                    ALU_Cin = ~lo_c_q;
                end else begin
                    ALU_Cin = 1'b0;
                end
            end
            default: begin
                ALU_Cin = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wide_d   = wide_q;
        s_d      = s_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_res_d = lo_res_q;
        lo_z_d   = lo_z_q;
        lo_c_d   = lo_c_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (Req_Valid) begin
                    op_d    = Req_OP;
                    wide_d  = Req_Wide && (Req_OP != 5'd17) && (Req_OP != 5'd18);
                    s_d     = Req_S;
                    a_d     = Req_A;
                    b_d     = Req_B;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (wide_q) begin
                    lo_res_d = ALU_Out;
                    lo_z_d   = ALU_Z;
                    lo_c_d   = ALU_C;
                    state_d  = ST_HI;
                end else begin
                    result_d = {32'd0, ALU_Out};
                    if (writes_flags(s_q, op_q)) begin
                        flags_d = {ALU_N, ALU_Z,
                                   is_arith(op_q) ? ALU_C : flags_q[1],
                                   is_arith(op_q) ? ALU_V : flags_q[0]};
                    end
                    state_d = ST_DONE;
                end
            end
            ST_HI: begin
                result_d = {ALU_Out, lo_res_q};
                if (writes_flags(s_q, op_q)) begin
                    flags_d = {ALU_N, lo_z_q & ALU_Z,
                               is_arith(op_q) ? ALU_C : flags_q[1],
                               is_arith(op_q) ? ALU_V : flags_q[0]};
                end
                state_d = ST_DONE;
            end
            default: begin
                if (Rsp_Ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 5'd0;
            wide_q   <= 1'b0;
            s_q      <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            lo_res_q <= 32'd0;
            lo_z_q   <= 1'b0;
            lo_c_q   <= 1'b0;
            result_q <= 64'd0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wide_q   <= wide_d;
            s_q      <= s_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_res_q <= lo_res_d;
            lo_z_q   <= lo_z_d;
            lo_c_q   <= lo_c_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [4:0]  Req_OP;
    logic        Req_Wide;
    logic        Req_S;
    logic [63:0] Req_A;
    logic [63:0] Req_B;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic [63:0] Rsp_Result;
    logic [3:0]  Flags;
    logic        Busy;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [4:0]  ALU_OP;
    logic        ALU_Cin;
    logic [31:0] ALU_Out;
    logic        ALU_Z;
    logic        ALU_V;
    logic        ALU_N;
    logic        ALU_C;

    int vectors = 0;
    int miscompares = 0;
    logic [67:0] sb[$];

    always #5 Clk = ~Clk;

    alu_sequencer dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_OP(Req_OP),
        .Req_Wide(Req_Wide), .Req_S(Req_S), .Req_A(Req_A), .Req_B(Req_B),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Result(Rsp_Result),
        .Flags(Flags), .Busy(Busy),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_Cin(ALU_Cin),
        .ALU_Out(ALU_Out), .ALU_Z(ALU_Z), .ALU_V(ALU_V), .ALU_N(ALU_N), .ALU_C(ALU_C)
    );

    // Subset of the ALU: AND, SUB/CMP, ADD, ADC, SBC; C on subtracts means borrow.
    logic [32:0] alu_t;
    always_comb begin
        alu_t   = 33'd0;
        ALU_Out = 32'd0;
        ALU_C   = 1'b0;
        ALU_V   = 1'b0;
        case (ALU_OP)
            5'd0: ALU_Out = ALU_A & ALU_B;
            5'd2, 5'd10: begin
                ALU_Out = ALU_A - ALU_B;
                ALU_C   = (ALU_A < ALU_B);
                ALU_V   = (ALU_A[31] != ALU_B[31]) && (ALU_Out[31] != ALU_A[31]);
            end
            5'd4, 5'd5: begin
                alu_t   = {1'b0, ALU_A} + {1'b0, ALU_B} + {32'd0, (ALU_OP == 5'd5) & ALU_Cin};
                ALU_Out = alu_t[31:0];
                ALU_C   = alu_t[32];
                ALU_V   = (ALU_A[31] == ALU_B[31]) && (ALU_Out[31] != ALU_A[31]);
            end
            5'd6: begin
                alu_t   = {1'b0, ALU_A} + {1'b0, ~ALU_B} + {32'd0, ALU_Cin};
                ALU_Out = alu_t[31:0];
                ALU_C   = ~alu_t[32];
                ALU_V   = (ALU_A[31] != ALU_B[31]) && (ALU_Out[31] != ALU_A[31]);
            end
            default: ALU_Out = 32'd0;
        endcase
        ALU_N = ALU_Out[31];
        ALU_Z = (ALU_Out == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [4:0] op, input logic w, input logic s,
                        input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (Req_Ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("req_ready_before_send", {63'd0, Req_Ready}, 64'd1);
        Req_OP = op; Req_Wide = w; Req_S = s; Req_A = a; Req_B = b;
        Req_Valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Req_Valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic lo_cin,
                            output logic [4:0] hi_op, output logic hi_cin);
        lat = 1; lo_cin = ALU_Cin; hi_op = ALU_OP; hi_cin = ALU_Cin;
        while (Rsp_Valid !== 1'b1 && lat < 20) begin
            @(posedge Clk);
            @(negedge Clk);
            lat++;
            if (lat == 2) begin
                hi_op  = ALU_OP;
                hi_cin = ALU_Cin;
            end
        end
    endtask

    task automatic check_rsp(input string tag);
        logic [67:0] e;
        check({tag, "_sb_nonempty"}, {63'd0, sb.size() != 0}, 64'd1);
        e = (sb.size() != 0) ? sb.pop_front() : {68{1'bx}};
        check({tag, "_result"}, Rsp_Result, e[67:4]);
        check({tag, "_flags"}, {60'd0, Flags}, {60'd0, e[3:0]});
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic w, input logic s,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic [3:0] fl, input int lat_exp,
                       output logic lo_cin, output logic [4:0] hi_op, output logic hi_cin);
        int lat;
        sb.push_back({res, fl});
        send(op, w, s, a, b);
        wait_rsp(lat, lo_cin, hi_op, hi_cin);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check_rsp(tag);
        Rsp_Ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rsp_Ready = 1'b0;
        check({tag, "_back_to_idle"}, {62'd0, Req_Ready, Busy}, 64'b10);
    endtask

    initial begin
        logic       lo_cin;
        logic [4:0] hi_op;
        logic       hi_cin;
        int         lat;

        Reset = 1'b1; Req_Valid = 1'b0; Req_OP = 5'd0; Req_Wide = 1'b0; Req_S = 1'b0;
        Req_A = 64'd0; Req_B = 64'd0; Rsp_Ready = 1'b0;
        #12;
        check("reset_flags", {60'd0, Flags}, 64'd0);
        check("reset_rsp", {61'd0, Rsp_Valid, Busy, Req_Ready}, 64'b001);
        check("reset_result", Rsp_Result, 64'd0);
        check("reset_alu", {ALU_A, ALU_B}, 64'd0);
        check("reset_alu_op", {58'd0, ALU_OP, ALU_Cin}, {58'd0, 5'b10000, 1'b0});
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        run("wide_add", 5'd4, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
            64'h0000_0001_0000_0000, 4'b0000, 3, lo_cin, hi_op, hi_cin);
        check("wide_add_hi_op", {59'd0, hi_op}, 64'd5);
        check("wide_add_hi_cin", {63'd0, hi_cin}, 64'd1);

        run("narrow_add", 5'd4, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1,
            64'h0000_0000_8000_0000, 4'b1001, 2, lo_cin, hi_op, hi_cin);

        run("wide_sub", 5'd2, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'd1,
            64'h0000_0000_FFFF_FFFF, 4'b1001, 3, lo_cin, hi_op, hi_cin);
        check("wide_sub_hi_op", {59'd0, hi_op}, 64'd6);
        check("wide_sub_hi_cin", {63'd0, hi_cin}, 64'd0);

        run("cmp_no_s", 5'd10, 1'b0, 1'b0, 64'd5, 64'd5,
            64'd0, 4'b0100, 2, lo_cin, hi_op, hi_cin);
        run("sub_borrow", 5'd2, 1'b0, 1'b1, 64'd0, 64'd1,
            64'h0000_0000_FFFF_FFFF, 4'b1010, 2, lo_cin, hi_op, hi_cin);
        run("logic_and", 5'd0, 1'b0, 1'b1, 64'hF0F0_F0F0, 64'hFF00_0000,
            64'h0000_0000_F000_0000, 4'b1010, 2, lo_cin, hi_op, hi_cin);
        run("adc_uses_c", 5'd5, 1'b0, 1'b0, 64'd1, 64'd2,
            64'd4, 4'b1010, 2, lo_cin, hi_op, hi_cin);
        check("adc_lo_cin", {63'd0, lo_cin}, 64'd1);

        sb.push_back({64'd7, 4'b1010});
        send(5'd4, 1'b0, 1'b0, 64'd3, 64'd4);
        wait_rsp(lat, lo_cin, hi_op, hi_cin);
        check("bp_latency", 64'(lat), 64'd2);
        check_rsp("bp");
        for (int i = 0; i < 5; i++) begin
            Req_Valid = (i % 2 == 0);
            Req_OP = 5'd2; Req_A = 64'd100; Req_B = 64'd1;
            @(posedge Clk);
            @(negedge Clk);
            check("bp_req_ready", {63'd0, Req_Ready}, 64'd0);
            check("bp_rsp_valid", {63'd0, Rsp_Valid}, 64'd1);
            check("bp_result_held", Rsp_Result, 64'd7);
        end
        Req_Valid = 1'b1;
        Rsp_Ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Rsp_Ready = 1'b0;
        Req_Valid = 1'b0;
        check("bp_release_idle", {62'd0, Req_Ready, Busy}, 64'b10);
        @(posedge Clk);
        @(negedge Clk);
        check("bp_nothing_accepted", {62'd0, Busy, Rsp_Valid}, 64'd0);

        send(5'd4, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        @(posedge Clk);
        @(negedge Clk);
        check("abort_in_hi", {59'd0, ALU_OP}, 64'd5);
        Reset = 1'b1;
        #1;
        check("abort_flags", {60'd0, Flags}, 64'd0);
        check("abort_state", {62'd0, Rsp_Valid, Busy}, 64'd0);
        check("abort_alu_idle", {58'd0, ALU_OP, ALU_Cin}, {58'd0, 5'b10000, 1'b0});
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        run("after_abort", 5'd4, 1'b0, 1'b1, 64'hFFFF_FFFF, 64'd1,
            64'd0, 4'b0110, 2, lo_cin, hi_op, hi_cin);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sits in front of the 32-bit ALU (`ALU_32bit`) and owns its operand, opcode and carry-in ports. It accepts one operation at a time over a valid/ready request channel and runs it as one ALU pass for 32-bit operations or two chained passes for 64-bit ("wide") operations. It also maintains the architectural NZCV condition-code register and returns results over a valid/ready response channel.

## Interface
Parameters: none; the ALU width (32) and opcode encoding (5-bit, `ALU_32bit` map) are fixed.

- `Clk`  in  1  single clock; all state changes on the rising edge
- `Reset`  in  1  asynchronous, active-high
- `Req_Valid`  in  1  request present
- `Req_Ready`  out  1  block can accept; 1 only in IDLE
- `Req_OP`  in  5  ALU opcode
- `Req_Wide`  in  1  64-bit operation (two passes)
- `Req_S`  in  1  write flags on completion
- `Req_A`, `Req_B`  in  64 each  operands; bits [63:32] ignored when `Req_Wide`=0
- `Rsp_Valid`  out  1  result available
- `Rsp_Ready`  in  1  consumer takes result
- `Rsp_Result`  out  64  result; [63:32]=0 for narrow ops
- `Flags`  out  4  registered {N,Z,C,V}
- `Busy`  out  1  state != IDLE
- `ALU_A`, `ALU_B`  out  32 each  ALU operands
- `ALU_OP`  out  5  ALU opcode
- `ALU_Cin`  out  1  ALU carry-in
- `ALU_Out`  in  32  ALU result
- `ALU_Z`, `ALU_V`, `ALU_N`, `ALU_C`  in  1 each  ALU flags (combinational)

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: `Req_Ready`=1. If `Req_Valid`=1 at the edge, latch OP, Wide, S, A, B and go to LO.
- LO: drive `ALU_A`/`ALU_B` with the low words and `ALU_OP`=latched OP. At the edge, capture `ALU_Out`, Z, N, C and V.
  - Narrow: go to DONE.
  - Wide: go to HI.
- HI: drive the high words and the high opcode.
  - Mapping: 4→5, 2→6, 3→7, 11→5, 10→6; 5, 6, 7 unchanged; every other opcode unchanged.
  - At the edge, capture the high result and go to DONE.
- Wide with OP 17 or 18 is illegal: execute as narrow.
- DONE: `Rsp_Valid`=1. `Rsp_Result` is held stable until the edge where `Rsp_Ready`=1, then go to IDLE.
- Carry-in:
  - LO pass of OP 5, 6, 7: `ALU_Cin` = `Flags.C`.
  - HI pass: `ALU_Cin` = low-pass C_Out for add-class ops (4, 5, 11).
  - HI pass: `ALU_Cin` = ~low-pass C_Out for subtract-class ops (2, 3, 6, 7, 10).
  - Otherwise `ALU_Cin`=0.
- Outside LO/HI: `ALU_OP`=5'b10000, `ALU_A`=`ALU_B`=0, `ALU_Cin`=0.
- Flag write: occurs at the completing capture edge (end of LO for narrow, end of HI for wide), only if `Req_S`=1 or OP is in 8..11.
  - N = sign bit of the final pass.
  - Z = AND of both passes' Z for wide; the ALU Z for narrow.
  - C and V come from the final pass for arithmetic ops (2–7, 10, 11, 17, 18). Logical ops preserve C and V.
- OP 8..11 (compare/test): `Rsp_Result` still returns the ALU value.

## Timing
- Reset (asynchronous, immediate):
  - State=IDLE; `Flags`=4'b0000; `Rsp_Valid`=0; `Rsp_Result`=0; `Busy`=0.
  - ALU ports at their idle values.
  - Reset mid-operation aborts: no flag write, no response.
- Accept at edge k:
  - Narrow: `Rsp_Valid` rises after edge k+1.
  - Wide: `Rsp_Valid` rises after edge k+2.
- Minimum issue interval: 3 cycles narrow, 4 cycles wide.
- The new `Flags` value is visible in the same cycle `Rsp_Valid` rises.
- `Req_Ready` is 0 from the edge after acceptance until return to IDLE. Requests presented then are ignored, not queued.
- `Rsp_Ready` held 0: stay in DONE indefinitely; outputs and `Flags` stable.
- `Rsp_Ready`=1 and a new `Req_Valid` in the same DONE cycle: the new request is accepted only in the following IDLE cycle.
- A back-to-back narrow OP 5 observes the `Flags.C` written by the previous op.

## Test plan
- Narrow ADD: OP=4, A=0x7FFFFFFF, B=1, S=1.
  - Result 0x80000000, `Flags`={1,0,0,1}.
  - `Rsp_Valid` 2 cycles after accept.
- Wide ADD carry chain: OP=4, A=0x00000000_FFFFFFFF, B=1, S=1.
  - HI pass shows `ALU_OP`=5 and `ALU_Cin`=1.
  - Result 0x00000001_00000000; Z=0.
- Wide SUB borrow chain: OP=2, A=0x00000001_00000000, B=1.
  - HI pass shows `ALU_OP`=6.
  - Result 0x00000000_FFFFFFFF.
  - `Flags` unchanged (S=0).
- CMP without S: OP=10, A=B=5, S=0 → Z=1 written. Then a logical OP=0 with S=1 whose result is nonzero → Z=0, C and V preserved.
- Backpressure: hold `Rsp_Ready`=0 for 5 cycles while toggling `Req_Valid` → `Req_Ready` stays 0, result held, nothing accepted. Release → IDLE next cycle.
- Reset during HI of a wide op with S=1 → `Flags`=0, `Rsp_Valid`=0, `Busy`=0 immediately. The next request completes normally.
